mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory stage of the 5-stage RISC-V pipeline: consumer of the execute stage's ex_to_mem_s
//  register. Performs word loads/stores over a req/ack data-memory bus, stalls upstream while
//  an access is outstanding, drives the MEM-stage bypass value and registers the mem_to_wb result.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in BUSY before the access is abandoned and mem_err set (>=1)
// PORTS
//  clk           in   1   clock, all state on posedge
//  rst           in   1   asynchronous, active-high reset
//  ex_to_mem     in   struct ex_to_mem_s {alu_result[31:0], write_data[31:0], mem_write, reg_write, rd[4:0], mem_read}
//  dmem_req      out  1   access request, held high until dmem_ack
//  dmem_we       out  1   1=store, 0=load; valid while dmem_req
//  dmem_addr     out  32  word address (byte address, [1:0]==0)
//  dmem_wdata    out  32  store data
//  dmem_ack      in   1   access complete this cycle; load data valid on dmem_rdata
//  dmem_rdata    in   32  load data
//  stall_mem     out  1   upstream (IF/DE/EX) must hold state, incl. ex_to_mem, this cycle
//  bp_mem        out  32  bypass value = ex_to_mem.alu_result (combinational)
//  wb_result     out  32  registered result to writeback
//  wb_rd         out  5   registered destination register
//  wb_reg_write  out  1   registered write enable
//  mem_err       out  1   sticky: misaligned access or timeout seen since reset
// BEHAVIOUR
//  Reset (async): state=IDLE, timeout counter=0, wb_result=0, wb_rd=0, wb_reg_write=0,
//   mem_err=0, latched request cleared; dmem_req=0, stall_mem=0 while rst high.
//  mem_op = ex_to_mem.mem_read | ex_to_mem.mem_write (mem_write wins if both set).
//  FSM IDLE:
//   - no mem_op: dmem_req=0, stall_mem=0; next edge wb_* <= {alu_result, rd, reg_write}.
//   - mem_op, alu_result[1:0]!=0: no request; mem_err<=1; wb_reg_write<=0; no stall.
//   - mem_op aligned: dmem_req=1 same cycle, addr/we/wdata driven from ex_to_mem and latched.
//     dmem_ack same cycle -> zero-wait completion: wb_result<=load?dmem_rdata:alu_result,
//     wb_reg_write<=reg_write, stall_mem=0. No ack -> stall_mem=1, next state BUSY, counter<=1.
//  FSM BUSY: bus driven from latched request (not ex_to_mem); dmem_req=1; stall_mem=1;
//   wb_reg_write<=0 each cycle (bubble to WB).
//   - dmem_ack: complete as above from latched fields; stall_mem=0 that cycle; -> IDLE.
//   - no ack, counter==TIMEOUT_CYCLES: drop dmem_req next cycle, mem_err<=1, wb_reg_write<=0,
//     stall_mem=0 this cycle, -> IDLE. Else counter<=counter+1 (saturating width $clog2+1).
//  ack while dmem_req=0 is ignored. Exactly one completion per request.
//  Store completion: wb_reg_write<=0 regardless of reg_write.
//  Upstream holds ex_to_mem stable while stall_mem=1; the stage must not re-issue it after
//   completion (the held op is consumed on the completing edge; IDLE issue on next new op).
//  bp_mem is not valid for loads; the hazard unit stalls load-use, this block does not.
//  Reset mid-access: request dropped immediately, no writeback, pending ack afterwards ignored.
// TESTING
//  1 ALU op rd=5 alu_result=0x1234, no mem_op -> next edge wb_result=0x1234, wb_rd=5, wb_reg_write=1, no stall.
//  2 Load addr 0x100, memory acks after 3 cycles with 0xDEADBEEF -> stall_mem high 3 cycles,
//    wb_reg_write=0 during stall, then wb_result=0xDEADBEEF, wb_reg_write=1 once.
//  3 Store addr 0x40 data 0xA5A5A5A5, ack same cycle -> dmem_we=1, dmem_wdata=0xA5A5A5A5,
//    zero stall, wb_reg_write=0.
//  4 Load addr 0x102 -> dmem_req never asserted, mem_err=1 and stays 1, wb_reg_write=0.
//  5 Load, no ack, TIMEOUT_CYCLES=4 -> stall 4 cycles, dmem_req drops, mem_err=1, IDLE resumes next op.
//  6 rst asserted in BUSY -> dmem_req/stall_mem/wb_reg_write=0 immediately; late ack ignored.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RISC-V pipeline: word loads/stores over a req/ack
// data-memory bus with upstream stall, timeout, sticky error and registered writeback.

package mem_stage_pkg;
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  rd;
    logic        mem_read;
  } ex_to_mem_s;
endpackage

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  mem_stage_pkg::ex_to_mem_s ex_to_mem,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [31:0]               dmem_addr,
  output logic [31:0]               dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [31:0]               dmem_rdata,
  output logic                      stall_mem,
  output logic [31:0]               bp_mem,
  output logic [31:0]               wb_result,
  output logic [4:0]                wb_rd,
  output logic                      wb_reg_write,
  output logic                      mem_err
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;

  // Request latched on entry to BUSY; the bus is driven from here while waiting.
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [4:0]  r_rd;
  logic        r_reg_write;

  logic [31:0] r_wb_result;
  logic [4:0]  r_wb_rd;
  logic        r_wb_reg_write;
  logic        r_mem_err;

  logic        w_mem_op;
  logic        w_aligned;
  logic        w_req;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_stall;
  logic [4:0]  w_cur_rd;
  logic        w_cur_reg_write;
  logic        w_complete;
  logic        w_wait_start;
  logic        w_timeout;
  logic        w_misalign;

  assign w_mem_op  = ex_to_mem.mem_read | ex_to_mem.mem_write;
  assign w_aligned = (ex_to_mem.alu_result[1:0] == 2'b00);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_next_state    = r_state;
    w_req           = 1'b0;
    w_we            = ex_to_mem.mem_write;
    w_addr          = ex_to_mem.alu_result;
    w_wdata         = ex_to_mem.write_data;
    w_cur_rd        = ex_to_mem.rd;
    w_cur_reg_write = ex_to_mem.reg_write;
    w_stall         = 1'b0;
    w_complete      = 1'b0;
    w_wait_start    = 1'b0;
    w_timeout       = 1'b0;
    w_misalign      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          if (!w_aligned) begin
            w_misalign = 1'b1;
          end else begin
            w_req = 1'b1;
            if (dmem_ack) begin
              w_complete = 1'b1;
            end else begin
              w_wait_start = 1'b1;
              w_stall      = 1'b1;
              w_next_state = S_BUSY;
            end
          end
        end
      end
      S_BUSY: begin
        w_req           = 1'b1;
        w_we            = r_we;
        w_addr          = r_addr;
        w_wdata         = r_wdata;
        w_cur_rd        = r_rd;
        w_cur_reg_write = r_reg_write;
        if (dmem_ack) begin
          w_complete   = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_cnt == CNT_MAX) begin
          // Abandon: release upstream now, request drops on the next cycle.
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase

    if (rst) begin
      w_req   = 1'b0;
      w_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_we           <= 1'b0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_wb_result    <= '0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
      r_mem_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next_state;
      if (w_complete) begin
        r_wb_result    <= w_we ? w_addr : dmem_rdata;
        r_wb_rd        <= w_cur_rd;
        r_wb_reg_write <= w_cur_reg_write & ~w_we;
      end else if (w_wait_start) begin
        r_addr         <= ex_to_mem.alu_result;
        r_wdata        <= ex_to_mem.write_data;
        r_we           <= ex_to_mem.mem_write;
        r_rd           <= ex_to_mem.rd;
        r_reg_write    <= ex_to_mem.reg_write;
        r_cnt          <= CNT_W'(1);
        r_wb_reg_write <= 1'b0;
      end else if (r_state == S_BUSY) begin
        r_wb_reg_write <= 1'b0;
        if (w_timeout) begin
          r_mem_err <= 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (w_misalign) begin
        r_mem_err      <= 1'b1;
        r_wb_reg_write <= 1'b0;
      end else begin
        r_wb_result    <= ex_to_mem.alu_result;
        r_wb_rd        <= ex_to_mem.rd;
        r_wb_reg_write <= ex_to_mem.reg_write;
      end
    end
  end

  assign dmem_req     = w_req;
  assign dmem_we      = w_we;
  assign dmem_addr    = w_addr;
  assign dmem_wdata   = w_wdata;
  assign stall_mem    = w_stall;
  assign bp_mem       = ex_to_mem.alu_result;
  assign wb_result    = r_wb_result;
  assign wb_rd        = r_wb_rd;
  assign wb_reg_write = r_wb_reg_write;
  assign mem_err      = r_mem_err;

endmodule
